// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and constants for the clock-divider controller.
// Optional feature macro used by clkdiv_ctrl: CLKDIV_CNT_EN (tick counter output).
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2,
    STOPPING = 2'd3
  } state_e;

  // Smallest legal half-period; a requested 0 is stored as this.
  localparam int unsigned DIV_MIN    = 1;
  localparam int unsigned TICK_CNT_W = 16;

  // A new divisor can be taken only when nothing is queued and no stop is in progress.
  function automatic logic cfg_ready_of(input state_e s);
    return (s == IDLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: half-period counter running 0..div-1; wrap flags the last cycle.
module clkdiv_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // div is never 0, so div-1 cannot underflow.
  assign wrap = (cnt_q == (div - W'(1)));
  assign cnt  = cnt_q;

  // Next count: clear wins, otherwise wrap to 0 at the end of the half period.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear || wrap) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: programmable clock divider with glitch-free divisor change and stop.
// Optional macro CLKDIV_CNT_EN adds the tick_cnt output (count of tick pulses).
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  input  logic         start,
  input  logic         stop,
  output logic         pclk,
  output logic         tick,
  output logic         busy
`ifdef CLKDIV_CNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_cnt
`endif
);

  state_e       state_q, state_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] div_nxt_q, div_nxt_d;
  logic         pclk_q, pclk_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic [W-1:0] div_clamped;
  logic [W-1:0] cnt;
  logic         wrap;
  logic         cfg_acc;
  logic         start_acc;
  logic         cnt_clear;

  assign cfg_ready   = cfg_ready_of(state_q);
  assign cfg_acc     = cfg_valid && cfg_ready;
  assign div_clamped = (cfg_div == '0) ? W'(DIV_MIN) : cfg_div;
  // stop beats start when both arrive in IDLE.
  assign start_acc   = (state_q == IDLE) && start && !stop;
  // Counter restarts from 0 on every start and sits at 0 while idle.
  assign cnt_clear   = start_acc || (state_d == IDLE);

  clkdiv_counter #(.W(W)) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .div   (div_q),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Next-state, divisor and divided-clock decode.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_nxt_d = div_nxt_q;
    pclk_d    = pclk_q;
    tick_d    = 1'b0;
    case (state_q)
      IDLE: begin
        pclk_d = 1'b0;
        if (cfg_acc) div_d = div_clamped;
        if (start_acc) state_d = RUN;
      end
      RUN, PEND: begin
        if (stop) begin
          // Low phase can end at once; a high phase must run to completion.
          if (!pclk_q) begin
            state_d = IDLE;
          end else if (wrap) begin
            pclk_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = STOPPING;
          end
        end else begin
          if (wrap) begin
            pclk_d = !pclk_q;
            tick_d = !pclk_q;
            // Swap divisors only at the falling toggle so no phase is cut short.
            if (state_q == PEND && pclk_q) begin
              div_d   = div_nxt_q;
              state_d = RUN;
            end
          end
          if (cfg_acc) begin
            div_nxt_d = div_clamped;
            state_d   = PEND;
          end
        end
      end
      STOPPING: begin
        if (wrap) begin
          pclk_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= W'(DIV_MIN);
      div_nxt_q <= W'(DIV_MIN);
      pclk_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_nxt_q <= div_nxt_d;
      pclk_q    <= pclk_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
    end
  end

  assign pclk = pclk_q;
  assign tick = tick_q;
  assign busy = busy_q;

  // The count always stays below the active divisor.
  cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt < div_q);

`ifdef CLKDIV_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

  // Tick counter: cleared by an accepted start, wraps naturally.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (start_acc) begin
      tick_cnt_d = '0;
    end else if (tick_q) begin
      tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: scoreboard bench for clkdiv_ctrl. Expected per-cycle outputs
// are built from phase lengths (half periods) and queued as stimulus is planned.
// Cycle 0 of a scenario is the cycle in which start is driven.
module tb_clkdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        start;
  logic        stop;
  logic        pclk;
  logic        tick;
  logic        busy;
`ifdef CLKDIV_CNT_EN
  logic [15:0] tick_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic pclk;
    logic tick;
    logic busy;
    logic ready;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        start;
    logic        stop;
    logic        cv;
    logic [15:0] cd;
  } stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];

  always #5 clk = ~clk;

  clkdiv_ctrl #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .pclk      (pclk),
    .tick      (tick),
    .busy      (busy)
`ifdef CLKDIV_CNT_EN
    ,
    .tick_cnt  (tick_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic p, input logic t, input logic b, input logic r);
    exp_t e;
    e.pclk  = p;
    e.tick  = t;
    e.busy  = b;
    e.ready = r;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One half period (or part of one) while busy; tick only on the first high cycle.
  task automatic push_phase(input logic lvl, input int len, input logic rdy, input logic first_tick);
    for (int i = 0; i < len; i++) push_exp(lvl, lvl && first_tick && (i == 0), 1'b1, rdy);
  endtask

  task automatic add_stim(input int cyc, input logic st, input logic sp, input logic cv, input logic [15:0] cd);
    stim_t s;
    s.cyc   = cyc;
    s.start = st;
    s.stop  = sp;
    s.cv    = cv;
    s.cd    = cd;
    stim_q.push_back(s);
  endtask

  task automatic pop_compare(input string where);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({where, " sb_depth"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({where, " pclk"},      32'(pclk),      32'(e.pclk));
      check_eq({where, " tick"},      32'(tick),      32'(e.tick));
      check_eq({where, " busy"},      32'(busy),      32'(e.busy));
      check_eq({where, " cfg_ready"}, 32'(cfg_ready), 32'(e.ready));
      $display("%s pclk=%0b tick=%0b busy=%0b cfg_ready=%0b", where, pclk, tick, busy, cfg_ready);
    end
  endtask

  // Drive planned stimulus cycle by cycle; compare at the falling edge.
  task automatic run_scn(input string name, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
      foreach (stim_q[i]) begin
        if (stim_q[i].cyc == c) begin
          start     = stim_q[i].start;
          stop      = stim_q[i].stop;
          cfg_valid = stim_q[i].cv;
          cfg_div   = stim_q[i].cd;
        end
      end
      @(negedge clk);
      pop_compare($sformatf("%s c%0d", name, c));
      @(posedge clk);
      #1;
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    stim_q.delete();
    check_eq({name, " leftover"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    push_idle(2);
    run_scn("reset", 0, 1);

    // Default divisor 1: period 2, then async reset while pclk is high.
    add_stim(0, 1'b1, 1'b0, 1'b0, 16'd0);
    push_idle(1);
    repeat (3) begin
      push_phase(1'b0, 1, 1'b1, 1'b0);
      push_phase(1'b1, 1, 1'b1, 1'b1);
    end
    push_phase(1'b0, 1, 1'b1, 1'b0);
    run_scn("div1", 0, 7);
    push_exp(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    pop_compare("div1 c8 pre-reset");
    rst_n = 1'b0;
    #1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1);
    pop_compare("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load 2, run, queue 5 during low phase (and a 9 while pending, ignored), stop while low.
    add_stim(-1, 1'b0, 1'b0, 1'b1, 16'd2);
    add_stim(0,  1'b1, 1'b0, 1'b0, 16'd0);
    add_stim(5,  1'b0, 1'b0, 1'b1, 16'd5);
    add_stim(7,  1'b0, 1'b0, 1'b1, 16'd9);
    add_stim(19, 1'b0, 1'b1, 1'b0, 16'd0);
    push_idle(2);
    push_phase(1'b0, 2, 1'b1, 1'b0);
    push_phase(1'b1, 2, 1'b1, 1'b1);
    push_phase(1'b0, 1, 1'b1, 1'b0);
    push_phase(1'b0, 1, 1'b0, 1'b0);
    push_phase(1'b1, 2, 1'b0, 1'b1);
    push_phase(1'b0, 5, 1'b1, 1'b0);
    push_phase(1'b1, 5, 1'b1, 1'b1);
    push_phase(1'b0, 1, 1'b1, 1'b0);
    push_idle(2);
    run_scn("div2to5", -1, 21);

    // cfg_div=0 clamps to 1; stop in a low cycle that is also a wrap cycle.
    add_stim(-1, 1'b0, 1'b0, 1'b1, 16'd0);
    add_stim(0,  1'b1, 1'b0, 1'b0, 16'd0);
    add_stim(5,  1'b0, 1'b1, 1'b0, 16'd0);
    push_idle(2);
    repeat (2) begin
      push_phase(1'b0, 1, 1'b1, 1'b0);
      push_phase(1'b1, 1, 1'b1, 1'b1);
    end
    push_phase(1'b0, 1, 1'b1, 1'b0);
    push_idle(2);
    run_scn("clamp0", -1, 7);

    // div=4: start while running is ignored; stop mid-high completes the high phase.
    add_stim(-1, 1'b0, 1'b0, 1'b1, 16'd4);
    add_stim(0,  1'b1, 1'b0, 1'b0, 16'd0);
    add_stim(2,  1'b1, 1'b0, 1'b0, 16'd0);
    add_stim(6,  1'b0, 1'b1, 1'b0, 16'd0);
    add_stim(7,  1'b0, 1'b0, 1'b1, 16'd3);
    push_idle(2);
    push_phase(1'b0, 4, 1'b1, 1'b0);
    push_phase(1'b1, 2, 1'b1, 1'b1);
    push_phase(1'b1, 2, 1'b0, 1'b0);
    push_idle(2);
    run_scn("stop_high", -1, 10);

    // start and stop together in IDLE: stays idle.
    add_stim(0, 1'b1, 1'b1, 1'b0, 16'd0);
    push_idle(4);
    run_scn("start_stop", 0, 3);

`ifdef CLKDIV_CNT_EN
    // Three periods at div=1, stop, then restart clears the tick count.
    add_stim(-1, 1'b0, 1'b0, 1'b1, 16'd1);
    add_stim(0,  1'b1, 1'b0, 1'b0, 16'd0);
    add_stim(7,  1'b0, 1'b1, 1'b0, 16'd0);
    push_idle(2);
    repeat (3) begin
      push_phase(1'b0, 1, 1'b1, 1'b0);
      push_phase(1'b1, 1, 1'b1, 1'b1);
    end
    push_phase(1'b0, 1, 1'b1, 1'b0);
    push_idle(1);
    run_scn("tick_cnt", -1, 8);
    @(negedge clk);
    check_eq("tick_cnt after 3 periods", 32'(tick_cnt), 32'd3);
    $display("tick_cnt idle tick_cnt=%0d", tick_cnt);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("tick_cnt after restart", 32'(tick_cnt), 32'd0);
    check_eq("busy after restart", 32'(busy), 32'd1);
    $display("tick_cnt restart tick_cnt=%0d busy=%0b", tick_cnt, busy);
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
